// File: rtl/pc_stack.sv
// pc_stack: WIDTH-bit program counter with reset/load/inc semantics and a
// DEPTH-entry return-address stack for call/ret. Sits between the decoder and
// the ROM address port.
// Optional feature: define PC_STACK_WRAP_EN to make the stack circular. A call
// while full then overwrites the oldest entry instead of dropping the return
// address.
module pc_stack #(
    parameter int               WIDTH        = 16,
    parameter int               DEPTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [AW-1:0]    top;      // slot the next push lands in
    logic [AW-1:0]    tos;      // slot holding the most recent entry
    logic [WIDTH-1:0] pc_inc;
    logic             st_we;
    logic [AW-1:0]    st_addr;

    assign pc_inc = out + WIDTH'(1);
    assign empty  = (sp == SW'(0));
    assign full   = (sp == SW'(DEPTH));
    assign tos    = top - AW'(1);

`ifdef PC_STACK_WRAP_EN
    // Separate ring pointer: once full, sp saturates at DEPTH while the ring
    // keeps rotating, so the low sp bits can no longer address the top.
    logic [AW-1:0] wp;
    assign top = wp;

    // Ring pointer follows every push and pop, including overwrite-on-full.
    always_ff @(posedge clock) begin
        if (reset)
            wp <= '0;
        else if (ret) begin
            if (!empty && !call)
                wp <= tos;
        end else if (call)
            wp <= top + AW'(1);
    end
`else
    // Without wrap, occupancy doubles as the push index (never used when full).
    assign top = sp[AW-1:0];
`endif

    // Stack write port: push at top, or swap rewrites the current top.
    always_comb begin
        st_we   = 1'b0;
        st_addr = top;
        if (!reset) begin
            if (ret) begin
                if (call && !empty) begin
                    st_we   = 1'b1;
                    st_addr = tos;
                end
            end else if (call) begin
`ifdef PC_STACK_WRAP_EN
                st_we = 1'b1;
`else
                st_we = !full;
`endif
            end
        end
    end

    // Stack storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clock) begin
        if (st_we)
            stack[st_addr] <= pc_inc;
    end

    // PC, occupancy and sticky flags, in priority order reset > ret > call > load > inc.
    always_ff @(posedge clock) begin
        if (reset) begin
            out       <= RESET_VECTOR;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (ret) begin
            // call&ret on empty degrades to a plain ret on empty
            if (empty)
                underflow <= 1'b1;
            else begin
                out <= stack[tos];
                if (!call)
                    sp <= sp - SW'(1);
            end
        end else if (call) begin
            out <= in;
            if (full)
                overflow <= 1'b1;
            else
                sp <= sp + SW'(1);
        end else if (load)
            out <= in;
        else if (inc)
            out <= pc_inc;
    end

endmodule
